// File: rtl/rgb_line_pingpong_ctrl.sv
// rgb_line_pingpong_ctrl: picks a free line-buffer bank per input line and hands completed lines to the reader in order.
// Optional macro RGB_PPC_OVF_CNT_EN adds ovf_cnt, a saturating count of dropped lines.
module rgb_line_pingpong_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int MAX_PIX = 1920
) (
    input  logic              clk_in1,
    input  logic              rst_n,
    input  logic              s_vld,
    input  logic              s_sol,
    input  logic              s_eol,
    input  logic [7:0]        s_r,
    input  logic [7:0]        s_g,
    input  logic [7:0]        s_b,
    output logic [7:0]        bram_a_wdata_r,
    output logic [7:0]        bram_a_wdata_g,
    output logic [7:0]        bram_a_wdata_b,
    output logic [ADDR_W-1:0] bram_a_waddr,
    output logic              bram1_a_wenb,
    output logic              bram2_a_wenb,
    output logic              line_vld,
    output logic              line_bank,
    output logic [ADDR_W:0]   line_len,
    input  logic              line_ack,
    output logic              ovf_pulse,
`ifdef RGB_PPC_OVF_CNT_EN
    output logic [15:0]       ovf_cnt,
`endif
    output logic              err_len
);
    localparam logic [ADDR_W:0] MAX_L = (ADDR_W+1)'(MAX_PIX);
    localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t            state, state_n;
    logic              bank, bank_n;
    logic [ADDR_W:0]   cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic              we, commit, ovf, err;
    logic [1:0]        full, full_n, free;
    logic              ptr, pick, sol, eol, pop;
    logic              pend, pend_bank;
    logic [ADDR_W:0]   pend_len;
    logic              t_vld, t_bank;
    logic [ADDR_W:0]   t_len;
    logic              h_vld_n, h_bank_n, t_vld_n, t_bank_n;
    logic [ADDR_W:0]   h_len_n, t_len_n;

    assign sol  = s_vld & s_sol;
    assign eol  = s_vld & s_eol;
    assign free = ~full;
    assign pick = free[ptr] ? ptr : ~ptr;
    assign pop  = line_ack & line_vld;

    // An early s_sol in WRITE restarts on the same bank, which was never marked full.
    always_comb begin
        state_n = state;
        bank_n  = bank;
        cnt_n   = cnt;
        addr_n  = '0;
        we      = 1'b0;
        commit  = 1'b0;
        ovf     = 1'b0;
        err     = 1'b0;
        if (state == WRITE) begin
            if (sol) begin
                err   = 1'b1;
                we    = 1'b1;
                cnt_n = ONE_L;
            end else if (s_vld) begin
                if (cnt < MAX_L) begin
                    we     = 1'b1;
                    addr_n = cnt[ADDR_W-1:0];
                    cnt_n  = cnt + ONE_L;
                end else begin
                    err = 1'b1;
                end
            end
            if (eol) begin
                commit  = 1'b1;
                state_n = IDLE;
            end
        end else if (sol) begin
            if (|free) begin
                bank_n  = pick;
                we      = 1'b1;
                cnt_n   = ONE_L;
                commit  = eol;
                state_n = eol ? IDLE : WRITE;
            end else begin
                ovf     = 1'b1;
                state_n = eol ? IDLE : DROP;
            end
        end else if (eol) begin
            state_n = IDLE;
        end
    end

    // The bank is reserved at s_eol so a following s_sol cannot pick it before the FIFO push.
    always_comb begin
        full_n = full;
        if (pop) full_n[line_bank] = 1'b0;
        if (commit) full_n[bank_n] = 1'b1;
    end

    always_comb begin
        h_vld_n  = pop ? t_vld : line_vld;
        h_bank_n = pop ? t_bank : line_bank;
        h_len_n  = pop ? t_len : line_len;
        t_vld_n  = pop ? 1'b0 : t_vld;
        t_bank_n = pop ? 1'b0 : t_bank;
        t_len_n  = pop ? '0 : t_len;
        if (pend && !h_vld_n) begin
            h_vld_n  = 1'b1;
            h_bank_n = pend_bank;
            h_len_n  = pend_len;
        end else if (pend) begin
            t_vld_n  = 1'b1;
            t_bank_n = pend_bank;
            t_len_n  = pend_len;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (!rst_n) begin
            state          <= IDLE;
            bank           <= 1'b0;
            cnt            <= '0;
            full           <= '0;
            ptr            <= 1'b0;
            pend           <= 1'b0;
            pend_bank      <= 1'b0;
            pend_len       <= '0;
            line_vld       <= 1'b0;
            line_bank      <= 1'b0;
            line_len       <= '0;
            t_vld          <= 1'b0;
            t_bank         <= 1'b0;
            t_len          <= '0;
            bram1_a_wenb   <= 1'b0;
            bram2_a_wenb   <= 1'b0;
            bram_a_waddr   <= '0;
            bram_a_wdata_r <= '0;
            bram_a_wdata_g <= '0;
            bram_a_wdata_b <= '0;
            ovf_pulse      <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            state        <= state_n;
            bank         <= bank_n;
            cnt          <= cnt_n;
            full         <= full_n;
            ptr          <= ptr ^ commit;
            pend         <= commit;
            line_vld     <= h_vld_n;
            line_bank    <= h_bank_n;
            line_len     <= h_len_n;
            t_vld        <= t_vld_n;
            t_bank       <= t_bank_n;
            t_len        <= t_len_n;
            bram1_a_wenb <= we & ~bank_n;
            bram2_a_wenb <= we & bank_n;
            ovf_pulse    <= ovf;
            err_len      <= err_len | err;
            if (commit) begin
                pend_bank <= bank_n;
                pend_len  <= cnt_n;
            end
            if (we) begin
                bram_a_waddr   <= addr_n;
                bram_a_wdata_r <= s_r;
                bram_a_wdata_g <= s_g;
                bram_a_wdata_b <= s_b;
            end
        end
    end

`ifdef RGB_PPC_OVF_CNT_EN
    always_ff @(posedge clk_in1) begin
        if (!rst_n) ovf_cnt <= '0;
        else if (ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rgb_line_pingpong_ctrl.sv
// tb_rgb_line_pingpong_ctrl: scenario tasks for the ping-pong line scheduler, writes scored against a queue.
module tb_rgb_line_pingpong_ctrl;
    typedef logic [36:0] wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_vld = 1'b0, s_sol = 1'b0, s_eol = 1'b0;
    logic [7:0]  s_r = '0, s_g = '0, s_b = '0;
    logic [7:0]  wd_r, wd_g, wd_b;
    logic [11:0] waddr;
    logic        wenb1, wenb2, line_vld, line_bank, ovf_pulse, err_len;
    logic [12:0] line_len;
    logic        line_ack = 1'b0;
`ifdef RGB_PPC_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif
    int  total = 0;
    int  bad = 0;
    wr_t wq[$];
    wr_t got, exp_w;

    rgb_line_pingpong_ctrl #(.ADDR_W(12), .MAX_PIX(16)) dut (
        .clk_in1(clk), .rst_n(rst_n), .s_vld(s_vld), .s_sol(s_sol), .s_eol(s_eol),
        .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .bram_a_wdata_r(wd_r), .bram_a_wdata_g(wd_g), .bram_a_wdata_b(wd_b),
        .bram_a_waddr(waddr), .bram1_a_wenb(wenb1), .bram2_a_wenb(wenb2),
        .line_vld(line_vld), .line_bank(line_bank), .line_len(line_len),
        .line_ack(line_ack), .ovf_pulse(ovf_pulse),
`ifdef RGB_PPC_OVF_CNT_EN
        .ovf_cnt(ovf_cnt),
`endif
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && (wenb1 || wenb2)) begin
            total++;
            got = {wenb2, waddr, wd_r, wd_g, wd_b};
            if (wenb1 && wenb2) begin
                bad++;
                $display("FAIL wenb_excl got both enables high, required one");
            end else if (wq.size() == 0) begin
                bad++;
                $display("FAIL stray_write got bank=%0d addr=%0d, required no write", wenb2, waddr);
            end else begin
                exp_w = wq.pop_front();
                if (got !== exp_w) begin
                    bad++;
                    $display("FAIL write got %h required %h", got, exp_w);
                end
            end
        end
    end

    task automatic drive(input logic sol, input logic eol, input logic [7:0] d,
                         input logic we, input logic bk, input int addr);
        s_vld = 1'b1; s_sol = sol; s_eol = eol;
        s_r = d; s_g = d + 8'h40; s_b = d ^ 8'hC3;
        if (we) wq.push_back({bk, 12'(addr), d, d + 8'h40, d ^ 8'hC3});
        @(posedge clk); #1;
        s_vld = 1'b0; s_sol = 1'b0; s_eol = 1'b0; line_ack = 1'b0;
    endtask

    task automatic send_line(input int n, input logic bk, input logic drop);
        for (int i = 0; i < n; i++) drive(i == 0, i == n - 1, 8'(i * 7 + 3), !drop && i < 16, bk, i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            line_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; line_ack = 1'b0; s_vld = 1'b0; s_sol = 1'b0; s_eol = 1'b0;
        wq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({line_vld, line_bank, line_len, wenb1, wenb2, waddr} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got vld=%0d bank=%0d len=%0d we=%0d%0d addr=%0d required 0",
                     line_vld, line_bank, line_len, wenb1, wenb2, waddr);
        end
        total++;
        if ({wd_r, wd_g, wd_b, ovf_pulse, err_len} !== '0) begin
            bad++;
            $display("FAIL reset_dat got %h ovf=%0d err=%0d required 0", {wd_r, wd_g, wd_b}, ovf_pulse, err_len);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_line();
        do_reset();
        send_line(8, 1'b0, 1'b0);
        total++;
        if (line_vld !== 1'b0) begin bad++; $display("FAIL t1_early_vld got=%0d required 0", line_vld); end
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd8}) begin
            bad++;
            $display("FAIL t1_head got vld=%0d bank=%0d len=%0d required 1/0/8", line_vld, line_bank, line_len);
        end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL t1_err got=%0d required 0", err_len); end
        line_ack = 1'b1;
        idle(1);
        total++;
        if (line_vld !== 1'b0) begin bad++; $display("FAIL t1_ack got vld=%0d required 0", line_vld); end
        total++;
        if (wq.size() !== 0) begin bad++; $display("FAIL t1_pending got %0d writes left required 0", wq.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_line(4, 1'b0, 1'b0);
        send_line(5, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 0);
        total++;
        if (ovf_pulse !== 1'b1) begin bad++; $display("FAIL t2_ovf got=%0d required 1", ovf_pulse); end
        drive(1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 0);
        total++;
        if (ovf_pulse !== 1'b0) begin bad++; $display("FAIL t2_ovf_len got=%0d required 0", ovf_pulse); end
        drive(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 0);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd4}) begin
            bad++;
            $display("FAIL t2_head0 got vld=%0d bank=%0d len=%0d required 1/0/4", line_vld, line_bank, line_len);
        end
        line_ack = 1'b1;
        drive(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 0);
        total++;
        if (ovf_pulse !== 1'b1) begin bad++; $display("FAIL t2_ack_sol got ovf=%0d required 1", ovf_pulse); end
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b1, 13'd5}) begin
            bad++;
            $display("FAIL t2_head1 got vld=%0d bank=%0d len=%0d required 1/1/5", line_vld, line_bank, line_len);
        end
        drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0);
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b1, 13'd5}) begin
            bad++;
            $display("FAIL t2_hold got vld=%0d bank=%0d len=%0d required 1/1/5", line_vld, line_bank, line_len);
        end
        line_ack = 1'b1;
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd1}) begin
            bad++;
            $display("FAIL t2_single got vld=%0d bank=%0d len=%0d required 1/0/1", line_vld, line_bank, line_len);
        end
        line_ack = 1'b1;
        idle(1);
        total++;
        if ({line_vld, err_len} !== 2'b00) begin
            bad++;
            $display("FAIL t2_empty got vld=%0d err=%0d required 0/0", line_vld, err_len);
        end
        total++;
        if (wq.size() !== 0) begin bad++; $display("FAIL t2_pending got %0d writes left required 0", wq.size()); end
    endtask

    task automatic test_truncate();
        do_reset();
        send_line(20, 1'b0, 1'b0);
        total++;
        if (err_len !== 1'b1) begin bad++; $display("FAIL t3_err got=%0d required 1", err_len); end
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd16}) begin
            bad++;
            $display("FAIL t3_head got vld=%0d bank=%0d len=%0d required 1/0/16", line_vld, line_bank, line_len);
        end
        total++;
        if (wq.size() !== 0) begin bad++; $display("FAIL t3_pending got %0d writes left required 0", wq.size()); end
    endtask

    task automatic test_early_sol();
        do_reset();
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b0, 8'(i + 100), 1'b1, 1'b0, i);
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL t4_err_pre got=%0d required 0", err_len); end
        send_line(6, 1'b0, 1'b0);
        total++;
        if (err_len !== 1'b1) begin bad++; $display("FAIL t4_err got=%0d required 1", err_len); end
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd6}) begin
            bad++;
            $display("FAIL t4_head got vld=%0d bank=%0d len=%0d required 1/0/6", line_vld, line_bank, line_len);
        end
        line_ack = 1'b1;
        idle(1);
        total++;
        if (line_vld !== 1'b0) begin bad++; $display("FAIL t4_one_line got vld=%0d required 0", line_vld); end
    endtask

    task automatic test_commit_ack();
        do_reset();
        send_line(3, 1'b0, 1'b0);
        idle(1);
        send_line(4, 1'b1, 1'b0);
        line_ack = 1'b1;
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b1, 13'd4}) begin
            bad++;
            $display("FAIL t5_head got vld=%0d bank=%0d len=%0d required 1/1/4", line_vld, line_bank, line_len);
        end
        send_line(2, 1'b0, 1'b0);
        total++;
        if (ovf_pulse !== 1'b0) begin bad++; $display("FAIL t5_ovf got=%0d required 0", ovf_pulse); end
        idle(1);
        line_ack = 1'b1;
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd2}) begin
            bad++;
            $display("FAIL t5_bank0 got vld=%0d bank=%0d len=%0d required 1/0/2", line_vld, line_bank, line_len);
        end
        total++;
        if (wq.size() !== 0) begin bad++; $display("FAIL t5_pending got %0d writes left required 0", wq.size()); end
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        send_line(2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(i == 0, 1'b0, 8'(i + 50), 1'b1, 1'b1, i);
        idle(1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({line_vld, line_len, wenb1, wenb2, waddr, wd_r, wd_g, wd_b, ovf_pulse, err_len} !== '0) begin
            bad++;
            $display("FAIL t6_reset got vld=%0d len=%0d we=%0d%0d addr=%0d err=%0d required 0",
                     line_vld, line_len, wenb1, wenb2, waddr, err_len);
        end
        rst_n = 1'b1;
        send_line(2, 1'b0, 1'b0);
        idle(1);
        total++;
        if ({line_vld, line_bank, line_len} !== {1'b1, 1'b0, 13'd2}) begin
            bad++;
            $display("FAIL t6_head got vld=%0d bank=%0d len=%0d required 1/0/2", line_vld, line_bank, line_len);
        end
        line_ack = 1'b1;
        idle(1);
        total++;
        if (line_vld !== 1'b0) begin bad++; $display("FAIL t6_fifo got vld=%0d required 0", line_vld); end
        total++;
        if (wq.size() !== 0) begin bad++; $display("FAIL t6_pending got %0d writes left required 0", wq.size()); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_overflow();
        test_truncate();
        test_early_sol();
        test_commit_ack();
        test_reset_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
